// File: rtl/scalar_dcache.sv
// scalar_dcache
//   Blocking, direct-mapped, write-through, no-write-allocate data cache for
//   the scalar load/store unit. Load hits complete in the request cycle.
//   Misses fill a whole line from memory one word at a time. All stores are
//   written through to memory. RAM traffic uses a single-word ready handshake.
//
// Parameters
//   SETS        number of lines (power of 2, >= 2)
//   BLOCK_WORDS words per line (power of 2, >= 1)
//   WORD_W      data/address width
//
// Ports
//   CLK, RST          clock (rising edge), asynchronous active-high reset
//   dmemREN/dmemWEN   load/store request from the LS unit (store wins)
//   dmemaddr          byte address, bits [1:0] ignored
//   dmemstore         store data
//   dmem_in           load data, nonzero only on a load hit
//   dhit_in           one-cycle request-complete pulse
//   ramREN/ramWEN     memory read/write request (never both)
//   ramaddr/ramstore  memory byte address / write data
//   ramload           memory read data, sampled when ram_ready=1
//   ram_ready         memory completed the current request
//
// Optional feature (macro SCALAR_DCACHE_PERF_EN)
//   Adds saturating 32-bit hit_count / miss_count outputs. Load hits that do
//   not follow a fill count as hits. Each IDLE->FILL transition counts as a miss.
module scalar_dcache #(
  parameter int unsigned SETS        = 16,
  parameter int unsigned BLOCK_WORDS = 2,
  parameter int unsigned WORD_W      = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              dmemREN,
  input  logic              dmemWEN,
  input  logic [WORD_W-1:0] dmemaddr,
  input  logic [WORD_W-1:0] dmemstore,
  output logic [WORD_W-1:0] dmem_in,
  output logic              dhit_in,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic              ram_ready
`ifdef SCALAR_DCACHE_PERF_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int unsigned WORD_BITS = $clog2(BLOCK_WORDS);
  localparam int unsigned IDX_BITS  = $clog2(SETS);
  localparam int unsigned OFF_BITS  = 2 + WORD_BITS;
  localparam int unsigned TAG_LSB   = OFF_BITS + IDX_BITS;
  localparam int unsigned TAG_W     = WORD_W - TAG_LSB;
  localparam int unsigned CNT_W     = (WORD_BITS == 0) ? 1 : WORD_BITS;
  localparam logic [WORD_W-1:0] LINE_MASK = (WORD_W'(1) << OFF_BITS) - WORD_W'(1);

  typedef logic [IDX_BITS-1:0] idx_t;
  typedef logic [TAG_W-1:0]    tag_t;
  typedef logic [CNT_W-1:0]    cnt_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE
  } state_t;

  function automatic idx_t idx_of(input logic [WORD_W-1:0] a);
    return idx_t'(a >> OFF_BITS);
  endfunction

  function automatic tag_t tag_of(input logic [WORD_W-1:0] a);
    return tag_t'(a >> TAG_LSB);
  endfunction

  function automatic cnt_t word_of(input logic [WORD_W-1:0] a);
    return (BLOCK_WORDS == 1) ? '0 : cnt_t'(a >> 2);
  endfunction

  state_t            state;
  logic [SETS-1:0]   valid;
  tag_t              tag_mem  [SETS];
  logic [WORD_W-1:0] data_mem [SETS][BLOCK_WORDS];
  logic [WORD_W-1:0] fill_buf [BLOCK_WORDS];
  cnt_t              cnt;
  logic [WORD_W-1:0] fill_base;
  logic [WORD_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic              just_filled;

  idx_t req_idx, fill_idx, wr_idx;
  tag_t req_tag, fill_tag;
  cnt_t req_word, wr_word;
  logic lookup_hit, wr_hit, fill_last;

  assign req_idx    = idx_of(dmemaddr);
  assign req_tag    = tag_of(dmemaddr);
  assign req_word   = word_of(dmemaddr);
  assign lookup_hit = valid[req_idx] && (tag_mem[req_idx] == req_tag);

  assign fill_idx   = idx_of(fill_base);
  assign fill_tag   = tag_of(fill_base);
  assign fill_last  = (cnt == cnt_t'(BLOCK_WORDS - 1));

  assign wr_idx     = idx_of(wr_addr);
  assign wr_word    = word_of(wr_addr);
  assign wr_hit     = valid[wr_idx] && (tag_mem[wr_idx] == tag_of(wr_addr));

  // Control state and valid bits. The fill address and the store are latched
  // on entry so that an abandoned request still completes its RAM side
  // consistently; with a stable requester the latched values equal the live
  // request.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      valid       <= '0;
      cnt         <= '0;
      fill_base   <= '0;
      wr_addr     <= '0;
      wr_data     <= '0;
      just_filled <= 1'b0;
`ifdef SCALAR_DCACHE_PERF_EN
      hit_count   <= '0;
      miss_count  <= '0;
`endif
    end else begin
      just_filled <= 1'b0;
      case (state)
        IDLE: begin
          if (dmemWEN) begin
            state   <= WRITE;
            wr_addr <= dmemaddr;
            wr_data <= dmemstore;
          end else if (dmemREN && !lookup_hit) begin
            state     <= FILL;
            cnt       <= '0;
            fill_base <= dmemaddr & ~LINE_MASK;
`ifdef SCALAR_DCACHE_PERF_EN
            if (miss_count != '1) miss_count <= miss_count + 32'd1;
`endif
          end else if (dmemREN && !just_filled) begin
`ifdef SCALAR_DCACHE_PERF_EN
            if (hit_count != '1) hit_count <= hit_count + 32'd1;
`endif
          end
        end
        FILL: begin
          if (ram_ready) begin
            cnt <= cnt + cnt_t'(1);
            if (fill_last) begin
              valid[fill_idx] <= 1'b1;
              state           <= IDLE;
              just_filled     <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (ram_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; valid bits gate every use.
  always_ff @(posedge CLK) begin
    if (state == FILL && ram_ready) begin
      fill_buf[cnt] <= ramload;
      if (fill_last) begin
        tag_mem[fill_idx] <= fill_tag;
        for (int unsigned w = 0; w < BLOCK_WORDS; w++) begin
          data_mem[fill_idx][w] <= (cnt_t'(w) == cnt) ? ramload : fill_buf[w];
        end
      end
    end
    if (state == WRITE && ram_ready && wr_hit) begin
      data_mem[wr_idx][wr_word] <= wr_data;
    end
  end

  // Outputs decode the state directly so an asynchronous reset clears them at once.
  always_comb begin
    dhit_in  = 1'b0;
    dmem_in  = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state)
      IDLE: begin
        if (!dmemWEN && dmemREN && lookup_hit) begin
          dhit_in = 1'b1;
          dmem_in = data_mem[req_idx][req_word];
        end
      end
      FILL: begin
        ramREN  = 1'b1;
        ramaddr = fill_base | (WORD_W'(cnt) << 2);
      end
      WRITE: begin
        ramWEN   = 1'b1;
        ramaddr  = wr_addr;
        ramstore = wr_data;
        dhit_in  = ram_ready;
      end
      default: ;
    endcase
  end

endmodule
